// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter unit.
//   pc_sel_t          : winning next-PC source
//   DEFAULT_*         : default parameter values for pc_unit
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_JMP,
        PC_CALL,
        PC_RET,
        PC_TRAP
    } pc_sel_t;

    localparam int unsigned DEFAULT_PC_W      = 16;
    localparam int unsigned DEFAULT_STEP      = 4;
    localparam int unsigned DEFAULT_RAS_DEPTH = 4;
    localparam logic [15:0] DEFAULT_RESET_VEC = 16'h0000;
    localparam logic [15:0] DEFAULT_TRAP_VEC  = 16'h0010;

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between decode/branch resolution and the PC unit.
//   master : drives redirect requests (stall, br, jump, call, ret, trap + targets)
//   slave  : the PC unit; drives pc and the RAS status flags
interface pc_unit_if #(
    parameter int unsigned PC_W = 16
);
    logic            stall;
    logic            br;
    logic [PC_W-1:0] br_add;
    logic            jump;
    logic            call;
    logic [PC_W-1:0] jump_add;
    logic            ret;
    logic            trap;
    logic [PC_W-1:0] pc;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    modport master (
        output stall, br, br_add, jump, call, jump_add, ret, trap,
        input  pc, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, br, br_add, jump, call, jump_add, ret, trap,
        output pc, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack with saturating depth counter.
//   push/pop/swap : one operation per cycle, push has precedence
//   din           : value written on push or swap
//   top           : entry at the top pointer
//   empty/full    : registered occupancy flags
//   ovf/unf       : this cycle's push overwrote the oldest entry / pop or swap on empty
module ras_stack #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            swap,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);
    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PC_W-1:0]  mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;

    // Pointer wrap works for any depth, not only powers of two.
    always_comb begin
        ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);
    end

    // Next-state: push overwrites the oldest slot when full; swap replaces top in place.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (push) begin
            ptr_d          = ptr_inc;
            mem_d[ptr_inc] = din;
            if (full_q) begin
                ovf = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop || swap) begin
            if (empty_q) begin
                unf = 1'b1;
            end else if (swap) begin
                mem_d[ptr_q] = din;
            end else begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_FULL);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign top   = mem_q[ptr_q];
    assign empty = empty_q;
    assign full  = full_q;
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects and a return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_unit_if slave; requests in, pc and RAS flags out (all registered)
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      PC_W      = DEFAULT_PC_W,
    parameter int unsigned      STEP      = DEFAULT_STEP,
    parameter logic [PC_W-1:0]  RESET_VEC = PC_W'(DEFAULT_RESET_VEC),
    parameter logic [PC_W-1:0]  TRAP_VEC  = PC_W'(DEFAULT_TRAP_VEC),
    parameter int unsigned      RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  bus
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ras_err_q, ras_err_d;
    logic [PC_W-1:0] pc_seq;
    pc_sel_t         sel;
    logic            hold;

    logic            ras_push, ras_pop, ras_swap;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty, ras_full, ras_ovf, ras_unf;

    // Source priority; trap overrides stall, stall discards everything else.
    always_comb begin
        sel  = PC_SEQ;
        hold = 1'b0;
        if (bus.trap) begin
            sel = PC_TRAP;
        end else if (bus.stall) begin
            hold = 1'b1;
        end else if (bus.ret) begin
            sel = PC_RET;
        end else if (bus.call) begin
            sel = PC_CALL;
        end else if (bus.jump) begin
            sel = PC_JMP;
        end else if (bus.br) begin
            sel = PC_BR;
        end
    end

    // Next PC and RAS control; call+ret becomes a top-of-stack swap.
    always_comb begin
        pc_seq    = pc_q + PC_W'(STEP);
        pc_d      = pc_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_swap  = 1'b0;
        if (!hold) begin
            unique case (sel)
                PC_SEQ:  pc_d = pc_seq;
                PC_BR:   pc_d = bus.br_add;
                PC_JMP:  pc_d = bus.jump_add;
                PC_CALL: begin
                    pc_d     = bus.jump_add;
                    ras_push = 1'b1;
                end
                PC_RET: begin
                    pc_d     = ras_empty ? TRAP_VEC : ras_top;
                    ras_swap = bus.call;
                    ras_pop  = !bus.call;
                end
                PC_TRAP: pc_d = TRAP_VEC;
                default: pc_d = pc_seq;
            endcase
        end
        ras_err_d = ras_err_q | ras_ovf | ras_unf;
    end

    // PC and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            ras_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ras_err_q <= ras_err_d;
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .swap  (ras_swap),
        .din   (pc_seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    assign bus.pc        = pc_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_err   = ras_err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector tables, reset sequences and a
// model-driven random phase, all checked through an expected-value queue.
module tb_pc_unit;
    typedef logic [15:0] addr_t;

    typedef struct {
        logic  stall;
        logic  br;
        addr_t br_add;
        logic  jump;
        logic  call;
        addr_t jump_add;
        logic  ret;
        logic  trap;
        addr_t e_pc;
        logic  e_empty;
        logic  e_full;
        logic  e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_unit_if #(.PC_W(16)) bus ();

    pc_unit #(
        .PC_W      (16),
        .STEP      (4),
        .RESET_VEC (16'h0000),
        .TRAP_VEC  (16'h0010),
        .RAS_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int    n_vec = 0;
    int    n_err = 0;
    vec_t  exp_q [$];
    string tag_q [$];

    // Reference model state
    addr_t m_pc;
    addr_t m_ras [$];
    logic  m_err;

    function automatic vec_t mk(input logic st, input logic b, input addr_t ba,
                                input logic jp, input logic cl, input addr_t ja,
                                input logic rt, input logic tr, input addr_t epc,
                                input logic ee, input logic ef, input logic er);
        vec_t v;
        v.stall = st; v.br = b; v.br_add = ba; v.jump = jp; v.call = cl;
        v.jump_add = ja; v.ret = rt; v.trap = tr;
        v.e_pc = epc; v.e_empty = ee; v.e_full = ef; v.e_err = er;
        return v;
    endfunction

    task automatic check(input string tag, input addr_t pc_w, input logic e_w,
                         input logic f_w, input logic r_w);
        n_vec++;
        if (bus.pc !== pc_w || bus.ras_empty !== e_w || bus.ras_full !== f_w ||
            bus.ras_err !== r_w) begin
            n_err++;
            $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, want pc=%h empty=%b full=%b err=%b",
                     tag, bus.pc, bus.ras_empty, bus.ras_full, bus.ras_err,
                     pc_w, e_w, f_w, r_w);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall = v.stall; bus.br = v.br; bus.br_add = v.br_add;
        bus.jump = v.jump; bus.call = v.call; bus.jump_add = v.jump_add;
        bus.ret = v.ret; bus.trap = v.trap;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 0));
    endtask

    // Drive at negedge, queue expectation, compare 1 time unit after the edge.
    task automatic apply(input string tag, input vec_t v);
        vec_t  e;
        string t;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got pc=%h want an entry", tag, bus.pc);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, e.e_pc, e.e_empty, e.e_full, e.e_err);
        end
    endtask

    // Release between posedge and negedge so the next edge is the first after reset.
    task automatic release_reset();
        @(posedge clk);
        #2;
        drive_idle();
        rst_n = 1'b1;
    endtask

    function automatic void model_step(input vec_t v);
        addr_t seq;
        addr_t t;
        seq = m_pc + 16'd4;
        if (v.trap) begin
            m_pc = 16'h0010;
        end else if (v.stall) begin
            m_pc = m_pc;
        end else if (v.ret) begin
            if (m_ras.size() == 0) begin
                m_pc  = 16'h0010;
                m_err = 1'b1;
            end else begin
                t = m_ras[m_ras.size() - 1];
                if (v.call) begin
                    m_ras[m_ras.size() - 1] = seq;
                end else begin
                    void'(m_ras.pop_back());
                end
                m_pc = t;
            end
        end else if (v.call) begin
            if (m_ras.size() == 4) begin
                void'(m_ras.pop_front());
                m_err = 1'b1;
            end
            m_ras.push_back(seq);
            m_pc = v.jump_add;
        end else if (v.jump) begin
            m_pc = v.jump_add;
        end else if (v.br) begin
            m_pc = v.br_add;
        end else begin
            m_pc = seq;
        end
    endfunction

    vec_t tbl1 [$];
    vec_t tbl2 [$];

    initial begin
        //           st br br_add   jp cl jump_add ret tr  pc       E  F  R
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0008, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h000C, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0020, 0, 0, 16'h0020, 1, 0, 0));
        tbl1.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h0080, 0, 0, 16'h0080, 1, 0, 0));
        tbl1.push_back(mk(1, 1, 16'h0040, 0, 1, 16'h0500, 0, 0, 16'h0080, 1, 0, 0));
        tbl1.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0080, 1, 0, 0));
        tbl1.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0010, 1, 0, 0));
        tbl1.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, 0, 0, 16'h0040, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 1, 0, 16'hFFFC, 0, 0, 16'hFFFC, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0100, 0, 0, 16'h0100, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0200, 0, 0, 16'h0200, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0300, 0, 0, 16'h0300, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0204, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0104, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0100, 0, 0, 16'h0100, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0300, 0, 0, 16'h0300, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0900, 1, 1, 16'h0010, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0300, 0, 0, 16'h0300, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0500, 1, 0, 16'h0104, 0, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0304, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0010, 1, 0, 1));
        tbl1.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0700, 0, 0, 16'h0010, 1, 0, 1));

        tbl2.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h2000, 0, 0, 16'h2000, 0, 0, 0));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h3000, 0, 0, 16'h3000, 0, 0, 0));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h4000, 0, 0, 16'h4000, 0, 1, 0));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h5000, 0, 0, 16'h5000, 0, 1, 1));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h4004, 0, 0, 1));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h3004, 0, 0, 1));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h2004, 0, 0, 1));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h1004, 1, 0, 1));
        tbl2.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0010, 1, 0, 1));

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'h0000, 1'b1, 1'b0, 1'b0);
        release_reset();

        for (int i = 0; i < tbl1.size(); i++) begin
            apply($sformatf("dir1_%0d", i), tbl1[i]);
        end

        // Asynchronous reset in the middle of a cycle, during a stalled call.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0);
        release_reset();

        for (int i = 0; i < tbl2.size(); i++) begin
            apply($sformatf("ovf_%0d", i), tbl2[i]);
        end

        // Model-checked random traffic from a fresh reset.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_pc  = 16'h0000;
        m_ras.delete();
        m_err = 1'b0;
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v.stall    = ($urandom_range(7) == 0);
            v.trap     = ($urandom_range(15) == 0);
            v.ret      = ($urandom_range(3) == 0);
            v.call     = ($urandom_range(3) == 0);
            v.jump     = ($urandom_range(3) == 0);
            v.br       = ($urandom_range(3) == 0);
            v.br_add   = addr_t'($urandom);
            v.jump_add = addr_t'($urandom);
            model_step(v);
            v.e_pc    = m_pc;
            v.e_empty = (m_ras.size() == 0);
            v.e_full  = (m_ras.size() == 4);
            v.e_err   = m_err;
            apply($sformatf("rand_%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
